// File: rtl/alu_sched_if.sv
// Requester, response and ALU-drive bundle for alu_sched.
// slave = scheduler side, master = requester/ALU side.
interface alu_sched_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req1_a, req0_b, req1_b;
   logic [7:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic [5:0]  rsp_flags;
   logic        rsp_err;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [7:0]  alu_op;
   logic [5:0]  alu_flags;
   logic        busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
      input  rsp0_ready, rsp1_ready, alu_out, alu_flags,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
      output alu_a, alu_b, alu_op, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
      output rsp0_ready, rsp1_ready, alu_out, alu_flags,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
      input  alu_a, alu_b, alu_op, busy
   );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler granting two requesters access to a registered ALU.
// Optional illegal-opcode rejection is enabled by defining ALU_SCHED_OPCHECK_EN.
module alu_sched #(
   parameter int ALU_LAT = 1
) (
   input logic        clk,
   input logic        rst,
   alu_sched_if.slave bus
);
   localparam int CW = $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t        r_state, w_next;
   logic          r_last, r_gnt;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a, r_b, r_res;
   logic [7:0]    r_op;
   logic [5:0]    r_flags;
   logic          w_gnt0, w_sel, w_acc, w_take, w_illegal;
   logic [31:0]   w_a, w_b;
   logic [7:0]    w_op;

   // Tie goes to the requester not granted last; r_last resets to 1 so req0 wins first.
   assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last);
   assign w_sel  = !w_gnt0;
   assign w_a    = w_sel ? bus.req1_a  : bus.req0_a;
   assign w_b    = w_sel ? bus.req1_b  : bus.req0_b;
   assign w_op   = w_sel ? bus.req1_op : bus.req0_op;
   assign w_take = r_gnt ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef ALU_SCHED_OPCHECK_EN
   logic r_err;

   always_comb begin
      case (w_op)
         8'h01, 8'h03, 8'h04, 8'h05, 8'h06,
         8'h07, 8'h08, 8'h09, 8'h0A: w_illegal = 1'b0;
         default:                    w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if (r_state == S_IDLE && w_acc)
         r_err <= w_illegal;
   end

   assign bus.rsp_err = r_err;
`else
   assign w_illegal   = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      w_acc          = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_acc          = (bus.req0_valid || bus.req1_valid) && !rst;
            bus.req0_ready = w_acc && !w_sel;
            bus.req1_ready = w_acc && w_sel;
            if (w_acc) w_next = w_illegal ? S_RESP : S_EXEC;
         end
         S_EXEC: if (r_cnt == '0) w_next = S_RESP;
         S_RESP: begin
            bus.rsp0_valid = !r_gnt;
            bus.rsp1_valid = r_gnt;
            if (w_take) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operands stay frozen through EXEC; counter zero marks alu_out as valid for capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last  <= 1'b1;
         r_gnt   <= 1'b0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 8'h00;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_acc) begin
               r_gnt  <= w_sel;
               r_last <= w_sel;
               r_cnt  <= CW'(ALU_LAT);
               if (w_illegal) begin
                  r_res   <= '0;
                  r_flags <= '0;
               end else begin
                  r_a  <= w_a;
                  r_b  <= w_b;
                  r_op <= w_op;
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  r_res   <= bus.alu_out;
                  r_flags <= bus.alu_flags;
                  r_op    <= 8'h00;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_a      = r_a;
   assign bus.alu_b      = r_b;
   assign bus.alu_op     = r_op;
   assign bus.rsp_result = r_res;
   assign bus.rsp_flags  = r_flags;
   assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: one DUT at ALU_LAT=1, one at ALU_LAT=3, each with an ALU model.
// Illegal-opcode expectations follow ALU_SCHED_OPCHECK_EN.
module tb_alu_sched;
   logic clk, rst;
   int   n_pass = 0, n_tot = 0;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic [5:0]  flg;
      logic        err;
   } exp_t;
   exp_t sbq[$];

   alu_sched_if bus();
   alu_sched_if bus3();

   alu_sched #(.ALU_LAT(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
   alu_sched #(.ALU_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {z,n,c,v,s,h, result}
   function automatic logic [37:0] alu_calc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic c, v, h;
      w = '0; r = '0; c = 1'b0; v = 1'b0; h = 1'b0;
      case (op)
         8'h00: return '0;
         8'h01: r = a;
         8'h03: begin
            w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
            h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
         end
         8'h04: begin
            w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
            h = a[3:0] < b[3:0];
         end
         8'h05: r = a & b;
         8'h06: r = a | b;
         8'h07: r = a ^ b;
         8'h08: r = ~a;
         8'h09: r = a << b[4:0];
         8'h0A: r = a >> b[4:0];
         default: r = ~(a ^ b);
      endcase
      return {(r == 32'd0), r[31], c, v, r[31] ^ v, h, r};
   endfunction

   function automatic exp_t mk_exp(input int id, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [37:0] m;
      m = alu_calc(op, a, b);
      e.id = id; e.res = m[31:0]; e.flg = m[37:32]; e.err = 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
      if (!(op inside {8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A})) begin
         e.res = '0; e.flg = '0; e.err = 1'b1;
      end
`endif
      return e;
   endfunction

   logic [37:0] m1, m3_0, m3_1, m3_2;
   always @(posedge clk) m1 <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
   always @(posedge clk) begin
      m3_0 <= alu_calc(bus3.alu_op, bus3.alu_a, bus3.alu_b);
      m3_1 <= m3_0;
      m3_2 <= m3_1;
   end
   assign bus.alu_out    = m1[31:0];
   assign bus.alu_flags  = m1[37:32];
   assign bus3.alu_out   = m3_2[31:0];
   assign bus3.alu_flags = m3_2[37:32];

   // Drives a request until granted; pushes the expectation at the accept edge.
   task automatic issue(input int id, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output bit ok);
      ok = 1'b0;
      if (id == 0) begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
      else         begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         ok = (id == 0) ? bus.req0_ready : bus.req1_ready;
         if (!ok) begin @(posedge clk); #1; end
      end
      if (ok) begin
         @(posedge clk);
         sbq.push_back(mk_exp(id, op, a, b));
         #1;
      end
      if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int bound, output int id);
      id = -1;
      for (int i = 0; i < bound && id < 0; i++) begin
         @(negedge clk);
         if (bus.rsp0_valid) id = 0;
         else if (bus.rsp1_valid) id = 1;
      end
   endtask

   task automatic take(input int id);
      if (id == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
   endtask

   function automatic exp_t pop_exp();
      exp_t e;
      e.id = -2; e.res = 'x; e.flg = 'x; e.err = 1'bx;
      if (sbq.size() > 0) e = sbq.pop_front();
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tot++; if (bus.req0_ready !== 1'b0) $display("FAIL rst_req0_ready got %0b want 0", bus.req0_ready); else n_pass++;
      n_tot++; if (bus.req1_ready !== 1'b0) $display("FAIL rst_req1_ready got %0b want 0", bus.req1_ready); else n_pass++;
      n_tot++; if (bus.rsp0_valid !== 1'b0) $display("FAIL rst_rsp0_valid got %0b want 0", bus.rsp0_valid); else n_pass++;
      n_tot++; if (bus.rsp1_valid !== 1'b0) $display("FAIL rst_rsp1_valid got %0b want 0", bus.rsp1_valid); else n_pass++;
      n_tot++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", bus.busy); else n_pass++;
      n_tot++; if (bus.rsp_result !== 32'd0) $display("FAIL rst_result got %h want 0", bus.rsp_result); else n_pass++;
      n_tot++; if (bus.rsp_flags !== 6'd0) $display("FAIL rst_flags got %b want 0", bus.rsp_flags); else n_pass++;
      n_tot++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_err got %0b want 0", bus.rsp_err); else n_pass++;
      n_tot++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) $display("FAIL rst_alu_ab got %h/%h want 0/0", bus.alu_a, bus.alu_b); else n_pass++;
      n_tot++; if (bus.alu_op !== 8'h00) $display("FAIL rst_alu_op got %h want 00", bus.alu_op); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_wrap();
      bit   ok;
      exp_t e;
      issue(0, 8'h03, 32'hFFFF_FFFF, 32'd1, ok);
      n_tot++; if (!ok) $display("FAIL add_accept got none want accept"); else n_pass++;
      @(negedge clk);
      n_tot++; if (bus.alu_op !== 8'h03 || bus.busy !== 1'b1) $display("FAIL add_exec op=%h busy=%0b want 03/1", bus.alu_op, bus.busy); else n_pass++;
      n_tot++; if (bus.rsp0_valid !== 1'b0) $display("FAIL add_early_rsp0 got %0b want 0 at edge 0", bus.rsp0_valid); else n_pass++;
      @(negedge clk);
      n_tot++; if (bus.rsp0_valid !== 1'b0) $display("FAIL add_early_rsp0 got %0b want 0 at edge 1", bus.rsp0_valid); else n_pass++;
      @(negedge clk);
      e = pop_exp();
      n_tot++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) $display("FAIL add_rsp_valid got %0b%0b want 10", bus.rsp0_valid, bus.rsp1_valid); else n_pass++;
      n_tot++; if (bus.rsp_result !== e.res) $display("FAIL add_result got %h want %h", bus.rsp_result, e.res); else n_pass++;
      n_tot++; if (bus.rsp_flags !== e.flg) $display("FAIL add_flags got %b want %b", bus.rsp_flags, e.flg); else n_pass++;
      n_tot++; if (bus.rsp_flags[5] !== 1'b1 || bus.rsp_flags[3] !== 1'b1) $display("FAIL add_zc got z=%0b c=%0b want 1/1", bus.rsp_flags[5], bus.rsp_flags[3]); else n_pass++;
      n_tot++; if (bus.alu_op !== 8'h00) $display("FAIL add_op_cleared got %h want 00", bus.alu_op); else n_pass++;
      take(0);
      n_tot++; if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0) $display("FAIL add_done busy=%0b rsp0=%0b want 0/0", bus.busy, bus.rsp0_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_exec();
      bit   ok;
      int   id, seen;
      exp_t e;
      issue(0, 8'h03, 32'd5, 32'd6, ok);
      n_tot++; if (!ok) $display("FAIL rme_accept got none want accept"); else n_pass++;
      rst = 1'b1;
      #1;
      n_tot++; if (bus.alu_op !== 8'h00 || bus.busy !== 1'b0) $display("FAIL rme_async op=%h busy=%0b want 00/0", bus.alu_op, bus.busy); else n_pass++;
      if (sbq.size() > 0) void'(sbq.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) seen++;
      end
      n_tot++; if (seen != 0) $display("FAIL rme_no_rsp got %0d valid cycles want 0", seen); else n_pass++;
      @(posedge clk); #1;
      issue(0, 8'h04, 32'd10, 32'd3, ok);
      n_tot++; if (!ok) $display("FAIL rme_next_accept got none want accept"); else n_pass++;
      wait_rsp(10, id);
      e = pop_exp();
      n_tot++; if (id != 0) $display("FAIL rme_next_id got %0d want 0", id); else n_pass++;
      n_tot++; if (bus.rsp_result !== e.res || bus.rsp_flags !== e.flg) $display("FAIL rme_next_data got %h/%b want %h/%b", bus.rsp_result, bus.rsp_flags, e.res, e.flg); else n_pass++;
      take(0);
   endtask

   task automatic test_round_robin();
      int   gseq[$], acc[$];
      int   nresp, both, rid;
      exp_t e;
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      nresp = 0; both = 0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      bus.req0_op = 8'h05; bus.req0_a = 32'hF0; bus.req0_b = 32'h0F; bus.req0_valid = 1'b1;
      bus.req1_op = 8'h06; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F; bus.req1_valid = 1'b1;
      for (int c = 0; c < 60 && nresp < 4; c++) begin
         @(negedge clk);
         if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both++;
         if (bus.req0_ready === 1'b1) begin
            gseq.push_back(0); acc.push_back(c); sbq.push_back(mk_exp(0, 8'h05, 32'hF0, 32'h0F));
         end else if (bus.req1_ready === 1'b1) begin
            gseq.push_back(1); acc.push_back(c); sbq.push_back(mk_exp(1, 8'h06, 32'hF0, 32'h0F));
         end
         if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
            rid = bus.rsp0_valid ? 0 : 1;
            e = pop_exp();
            n_tot++; if (rid != e.id) $display("FAIL rr_route got %0d want %0d", rid, e.id); else n_pass++;
            n_tot++; if (bus.rsp_result !== e.res) $display("FAIL rr_result got %h want %h", bus.rsp_result, e.res); else n_pass++;
            n_tot++; if (bus.rsp_flags !== e.flg) $display("FAIL rr_flags got %b want %b", bus.rsp_flags, e.flg); else n_pass++;
            nresp++;
         end
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      n_tot++; if (nresp != 4) $display("FAIL rr_count got %0d want 4", nresp); else n_pass++;
      n_tot++; if (both != 0) $display("FAIL rr_both_ready got %0d want 0", both); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_tot++;
         if (i >= gseq.size() || gseq[i] != (i % 2)) $display("FAIL rr_grant%0d got %0d want %0d", i, (i < gseq.size()) ? gseq[i] : -1, i % 2);
         else n_pass++;
      end
      for (int i = 0; i + 1 < acc.size(); i++) begin
         n_tot++;
         if (acc[i+1] - acc[i] != 4) $display("FAIL rr_spacing%0d got %0d want 4", i, acc[i+1] - acc[i]); else n_pass++;
      end
   endtask

   task automatic test_back_pressure();
      bit   ok;
      int   id, held, r0seen, found;
      exp_t e;
      bus.rsp1_ready = 1'b0;
      issue(1, 8'h07, 32'hF0, 32'h0F, ok);
      n_tot++; if (!ok) $display("FAIL bp_accept got none want accept"); else n_pass++;
      bus.req0_op = 8'h03; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_valid = 1'b1;
      r0seen = 0; found = 0; held = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (bus.req0_ready !== 1'b0) r0seen++;
         if (bus.rsp1_valid === 1'b1) found = 1;
      end
      n_tot++; if (!found) $display("FAIL bp_rsp1_timeout got none want rsp1_valid"); else n_pass++;
      e = pop_exp();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.req0_ready !== 1'b0) r0seen++;
         if (bus.rsp1_valid === 1'b1 && bus.rsp_result === e.res && bus.rsp_result === 32'hFF) held++;
      end
      n_tot++; if (held != 5) $display("FAIL bp_hold got %0d cycles want 5", held); else n_pass++;
      n_tot++; if (r0seen != 0) $display("FAIL bp_req0_ready got %0d cycles want 0", r0seen); else n_pass++;
      n_tot++; if (e.id != 1) $display("FAIL bp_sb_id got %0d want 1", e.id); else n_pass++;
      take(1);
      @(negedge clk);
      n_tot++; if (bus.req0_ready !== 1'b1) $display("FAIL bp_next_accept got %0b want 1", bus.req0_ready); else n_pass++;
      @(posedge clk);
      sbq.push_back(mk_exp(0, 8'h03, 32'd5, 32'd7));
      #1;
      bus.req0_valid = 1'b0;
      wait_rsp(10, id);
      e = pop_exp();
      n_tot++; if (id != 0 || bus.rsp_result !== e.res) $display("FAIL bp_req0_rsp got id %0d %h want 0 %h", id, bus.rsp_result, e.res); else n_pass++;
      take(0);
   endtask

   task automatic test_illegal_op();
      bit   ok;
      int   id;
      exp_t e;
      issue(0, 8'h02, 32'd3, 32'd4, ok);
      n_tot++; if (!ok) $display("FAIL ill_accept got none want accept"); else n_pass++;
      @(negedge clk);
`ifdef ALU_SCHED_OPCHECK_EN
      e = pop_exp();
      n_tot++; if (bus.alu_op !== 8'h00) $display("FAIL ill_alu_op got %h want 00", bus.alu_op); else n_pass++;
      n_tot++; if (bus.rsp0_valid !== 1'b1) $display("FAIL ill_rsp0 got %0b want 1", bus.rsp0_valid); else n_pass++;
      n_tot++; if (bus.rsp_err !== e.err || bus.rsp_result !== e.res || bus.rsp_flags !== e.flg)
         $display("FAIL ill_data got err %0b %h %b want %0b %h %b", bus.rsp_err, bus.rsp_result, bus.rsp_flags, e.err, e.res, e.flg);
      else n_pass++;
      take(0);
`else
      n_tot++; if (bus.alu_op !== 8'h02) $display("FAIL ill_alu_op got %h want 02", bus.alu_op); else n_pass++;
      wait_rsp(10, id);
      e = pop_exp();
      n_tot++; if (id != 0) $display("FAIL ill_rsp_id got %0d want 0", id); else n_pass++;
      n_tot++; if (bus.rsp_err !== 1'b0 || bus.rsp_result !== e.res) $display("FAIL ill_data got err %0b %h want 0 %h", bus.rsp_err, bus.rsp_result, e.res); else n_pass++;
      take(0);
`endif
   endtask

   task automatic test_lat3();
      int          held;
      logic [31:0] smp;
      logic [5:0]  smpf;
      bus3.req1_op = 8'h09; bus3.req1_a = 32'hFFFF; bus3.req1_b = 32'd3; bus3.req1_valid = 1'b1;
      @(negedge clk);
      n_tot++; if (bus3.req1_ready !== 1'b1) $display("FAIL l3_ready got %0b want 1", bus3.req1_ready); else n_pass++;
      @(posedge clk); #1;
      bus3.req1_valid = 1'b0;
      held = 0; smp = '0; smpf = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus3.alu_op === 8'h09 && bus3.rsp1_valid === 1'b0) held++;
         smp = bus3.alu_out; smpf = bus3.alu_flags;
      end
      @(negedge clk);
      n_tot++; if (held != 4) $display("FAIL l3_op_hold got %0d cycles want 4", held); else n_pass++;
      n_tot++; if (bus3.rsp1_valid !== 1'b1 || bus3.rsp0_valid !== 1'b0) $display("FAIL l3_rsp_valid got %0b%0b want 01", bus3.rsp0_valid, bus3.rsp1_valid); else n_pass++;
      n_tot++; if (bus3.rsp_result !== smp || bus3.rsp_flags !== smpf) $display("FAIL l3_capture got %h want %h", bus3.rsp_result, smp); else n_pass++;
      n_tot++; if (bus3.rsp_result !== 32'h0007_FFF8) $display("FAIL l3_result got %h want 0007fff8", bus3.rsp_result); else n_pass++;
      n_tot++; if (bus3.alu_op !== 8'h00) $display("FAIL l3_op_clear got %h want 00", bus3.alu_op); else n_pass++;
      bus3.rsp1_ready = 1'b1;
      @(posedge clk); #1;
      bus3.rsp1_ready = 1'b0;
      n_tot++; if (bus3.busy !== 1'b0) $display("FAIL l3_idle busy got %0b want 0", bus3.busy); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0; bus3.rsp0_ready = 1'b0; bus3.rsp1_ready = 1'b0;
      bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_op = '0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_op = '0;
      test_reset();
      test_add_wrap();
      test_reset_mid_exec();
      test_round_robin();
      test_back_pressure();
      test_illegal_op();
      test_lat3();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the 32-bit registered ALU. It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU operand/opcode ports, waits out the ALU pipeline latency, captures the result and six status flags, and returns them to the granted requester. It sits between the instruction-issue logic and the ALU and is the only block that drives the ALU inputs.

## Interface
- ALU_LAT, 1, ALU clock latency: edges from operands stable at ALU inputs to result valid on alu_out (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req1_a  in  32  operand A
- req0_b, req1_b  in  32  operand B
- req0_op, req1_op  in  8  ALU opcode
- rsp0_valid / rsp1_valid  out  1  response available to that requester
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp_result  out  32  captured ALU result (shared; qualified by rspN_valid)
- rsp_flags  out  6  captured {z,n,c,v,s,h}
- rsp_err  out  1  operation rejected as illegal opcode
- alu_a, alu_b  out  32  ALU operands (registered)
- alu_op  out  8  ALU opcode (registered); 8'h00 = no-op
- alu_out  in  32  ALU result
- alu_flags  in  6  ALU {z,n,c,v,s,h}
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant combinationally. If both are valid, grant the requester not granted last. last_grant resets to 1, so req0 wins the first tie. Only the granted reqN_ready is high. At the accept edge, register alu_a/alu_b/alu_op from the granted inputs, record the grant, load wait counter = ALU_LAT, and go to EXEC.
- EXEC: hold alu_a/b/op stable. The counter decrements each edge. At the edge where the counter reaches 0, capture alu_out → rsp_result and alu_flags → rsp_flags, clear rsp_err, drive alu_op to 8'h00, and go to RESP.
- RESP: assert rspN_valid for the recorded grant only; rsp_result, rsp_flags and rsp_err are held stable. When rspN_ready is high at an edge, go to IDLE. No new request is accepted in RESP or EXEC.
- Legal opcodes: 01 LD, 03 ADD, 04 SUB, 05 AND, 06 OR, 07 XOR, 08 NOT, 09 SL, 0A SR.
- Requests are never reordered or dropped. Each accept produces exactly one response, to the accepted requester.

## Timing
- Reset values:
  - req*_ready = 0, rsp*_valid = 0, busy = 0.
  - rsp_result = 0, rsp_flags = 0, rsp_err = 0.
  - alu_a = alu_b = 0, alu_op = 8'h00.
  - State = IDLE, last_grant = 1.
- Legal op: rspN_valid rises after the (ALU_LAT+1)th rising edge following the accept edge.
- Minimum accept-to-accept spacing: ALU_LAT+3 cycles (EXEC, RESP with immediate ready, one IDLE cycle).
- Response with rspN_ready already high: consumed on the first RESP edge.
- Requester deasserting reqN_valid before grant is legal; no accept occurs.
- rst asserted in any state forces reset values immediately. An in-flight operation is discarded with no response, and alu_op returns to 8'h00 without waiting for clk.

## Configuration
- ALU_SCHED_OPCHECK_EN defined:
  - An opcode outside the legal list is still accepted (ready handshake occurs) but is never issued to the ALU; alu_op stays 8'h00.
  - The accept edge goes directly to RESP with rsp_result = 0, rsp_flags = 0, rsp_err = 1.
  - rspN_valid rises after the accept edge.
- Not defined: every opcode is forwarded unchanged through EXEC; rsp_err is tied to 0.

## Test plan
- Reset mid-EXEC: accept req0 ADD, assert rst in the first EXEC cycle → alu_op = 00, busy = 0, no rsp0_valid, and the next request is accepted normally.
- req0 ADD a=FFFFFFFF, b=1, ALU_LAT=1 → rsp0_valid after the 2nd edge following accept, rsp_result = 0, rsp_flags z=1 and c=1; rsp1_valid stays 0.
- Both requesters valid continuously: req0 AND (F0, 0F) and req1 OR (F0, 0F) → grants alternate 0,1,0,1. Results are 0 (z=1) and FF (z=0), each routed to its own requester.
- Back-pressure: rsp1_ready held low 5 cycles after a req1 XOR (F0, 0F) → rsp1_valid and rsp_result = FF held for 5 cycles, req0_ready stays 0 throughout, and the next accept occurs only after the rsp1 handshake.
- With ALU_SCHED_OPCHECK_EN, req0 op=8'h02 → accepted, alu_op never leaves 00, rsp_err = 1 and rsp_result = 0 one edge after accept. Without the macro, op 02 appears on alu_op and rsp_err = 0.
- ALU_LAT=3, req1 SL a=FFFF, b=3 → alu_op = 09 held for 4 cycles, rsp1_valid after the 4th edge following accept, and rsp_result equals alu_out sampled at that edge.
